// File: rtl/counter_sequencer_pkg.sv
// Shared definitions for the counter sequencer: FSM state encoding and
// count-direction constants.
package counter_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_sequencer_updown_reg.sv
// WIDTH-bit up/down state register with synchronous parallel load, step
// enable, and a registered wrap flag raised on the step that wraps q.
module updown_reg
  import counter_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic             wrap
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;

  // Next value: load wins over a step; wrap flags max->0 (up) or 0->max (down).
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (load) begin
      q_d = load_val;
    end else if (en) begin
      if (dir == DIR_UP) begin
        q_d    = q_q + WIDTH'(1);
        wrap_d = (q_q == '1);
      end else if (dir == DIR_DOWN) begin
        q_d    = q_q - WIDTH'(1);
        wrap_d = (q_q == '0);
      end
    end
  end

  // State register and wrap flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/counter_sequencer.sv
// Sequencer that runs the up/down state register for a commanded number of
// steps, reporting Busy while running and a one-cycle Done on completion.
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned STEP_W = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              C,
  input  logic [STEP_W-1:0] Steps,
  input  logic              Hold,
  input  logic              Load,
  input  logic [WIDTH-1:0]  LoadVal,
  output logic [WIDTH-1:0]  Q,
  output logic              Busy,
  output logic              Done,
  output logic              Wrap
);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic              dir_q, dir_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              reg_load;
  logic              reg_en;

  // Command FSM: next state, step counter, latched direction and flag outputs.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    dir_d    = dir_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    reg_load = 1'b0;
    reg_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Load) begin
          reg_load = 1'b1;
        end else if (Start) begin
          if (Steps != '0) begin
            state_d = RUN;
            rem_d   = Steps;
            dir_d   = C;
            busy_d  = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        busy_d = 1'b1;
        if (!Hold) begin
          reg_en = 1'b1;
          rem_d  = rem_q - STEP_W'(1);
          if (rem_q == STEP_W'(1)) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and output registers; reset aborts any command without a Done pulse.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dir_q   <= DIR_DOWN;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  updown_reg #(
    .WIDTH (WIDTH)
  ) u_updown_reg (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .load     (reg_load),
    .load_val (LoadVal),
    .en       (reg_en),
    .dir      (dir_q),
    .q        (Q),
    .wrap     (Wrap)
  );

  assign Busy = busy_q;
  assign Done = done_q;

endmodule
